// File: rtl/reg_delay_pkg.sv
// Shared constants and helpers for the configurable register delay pipe.
// Imported by reg_delay_stage and reg_delay_pipe.
package reg_delay_pkg;

    localparam int REG_DELAY_MAX_DEPTH = 16;
    localparam int REG_DELAY_DEF_WIDTH = 18;

    // Bits needed to count from 0 up to depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_delay_stage.sv
// One pipe stage: data register plus valid flag.
// Data moves on en regardless of valid; flush only clears the flag.
module reg_delay_stage
    import reg_delay_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DELAY_DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    // Data register advances on enable, independent of valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (en) begin
            out_data <= in_data;
        end
    end

    // Valid flag: flush wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: rtl/reg_delay_pipe.sv
// Configurable DEPTH-stage register delay with valid, stall and flush.
// Define REG_DELAY_PIPE_OCC_EN to add the occupancy counter output.
module reg_delay_pipe
    import reg_delay_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DELAY_DEF_WIDTH,
    parameter int DEPTH      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef REG_DELAY_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    if (DEPTH < 1 || DEPTH > REG_DELAY_MAX_DEPTH) begin : g_bad_depth
        $error("reg_delay_pipe: DEPTH must be in 1..16");
    end

    logic [DEPTH:0]          vchain;
    logic [DATA_WIDTH-1:0]   dchain [DEPTH+1];

    assign vchain[0] = in_valid;
    assign dchain[0] = in_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        reg_delay_stage #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .flush    (flush),
            .in_valid (vchain[k]),
            .in_data  (dchain[k]),
            .out_valid(vchain[k+1]),
            .out_data (dchain[k+1])
        );
    end

    assign out_valid = vchain[DEPTH];
    assign out_data  = dchain[DEPTH];

`ifdef REG_DELAY_PIPE_OCC_EN
    localparam int OW = occ_width(DEPTH);

    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

    // Entry adds one, exit from the last stage removes one.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + OW'(in_valid) - OW'(vchain[DEPTH]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_reg_delay_pipe.sv
// Scoreboard bench for reg_delay_pipe at DEPTH 3, 4 and 1.
// Occupancy checks are active when REG_DELAY_PIPE_OCC_EN is defined.
module tb_reg_delay_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        en3 = 1'b0;
    logic        en4 = 1'b0;
    logic        en1 = 1'b0;

    logic        ov3, ov4, ov1;
    logic [17:0] od3, od4;
    logic [31:0] od1;
`ifdef REG_DELAY_PIPE_OCC_EN
    logic [1:0]  occ3;
    logic [2:0]  occ4;
    logic        occ1;
`endif

    int checks = 0;
    int errors = 0;

    logic [17:0] q3 [$];
    logic [17:0] q4 [$];
    logic [31:0] q1 [$];

    always #5 clk = ~clk;

    reg_delay_pipe #(.DATA_WIDTH(18), .DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[17:0]),
        .out_valid(ov3), .out_data(od3)
`ifdef REG_DELAY_PIPE_OCC_EN
        , .occupancy(occ3)
`endif
    );

    reg_delay_pipe #(.DATA_WIDTH(18), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[17:0]),
        .out_valid(ov4), .out_data(od4)
`ifdef REG_DELAY_PIPE_OCC_EN
        , .occupancy(occ4)
`endif
    );

    reg_delay_pipe #(.DATA_WIDTH(32), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov1), .out_data(od1)
`ifdef REG_DELAY_PIPE_OCC_EN
        , .occupancy(occ1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every valid output must match the next queued entry.
    always @(negedge clk) begin
        if (rst_n && ov3) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL d3_unexpected: got %h expected none", od3);
            end else begin
                logic [17:0] e;
                e = q3.pop_front();
                if (od3 !== e) begin
                    errors++;
                    $display("FAIL d3_data: got %h expected %h", od3, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL d4_unexpected: got %h expected none", od4);
            end else begin
                logic [17:0] e;
                e = q4.pop_front();
                if (od4 !== e) begin
                    errors++;
                    $display("FAIL d4_data: got %h expected %h", od4, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL d1_unexpected: got %h expected none", od1);
            end else begin
                logic [31:0] e;
                e = q1.pop_front();
                if (od1 !== e) begin
                    errors++;
                    $display("FAIL d1_data: got %h expected %h", od1, e);
                end
            end
        end
    end

    initial begin
        // Reset state
        #3;
        chk("rst_ov3", 32'(ov3), 32'd0);
        chk("rst_od3", 32'(od3), 32'd0);
        chk("rst_ov4", 32'(ov4), 32'd0);
        chk("rst_od1", od1, 32'd0);
`ifdef REG_DELAY_PIPE_OCC_EN
        chk("rst_occ3", 32'(occ3), 32'd0);
`endif
        step();
        step();
        rst_n = 1'b1;

        // Basic three-deep latency
        en3 = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 32'(i);
            q3.push_back(18'(i));
            chk("lat_ov_early", 32'(ov3), 32'd0);
            step();
        end
        in_valid = 1'b0;
        chk("lat_c3_ov", 32'(ov3), 32'd1);
        chk("lat_c3_od", 32'(od3), 32'h1);
        step();
        chk("lat_c4_od", 32'(od3), 32'h2);
        step();
        chk("lat_c5_od", 32'(od3), 32'h3);
        step();
        chk("lat_c6_ov", 32'(ov3), 32'd0);

        // Stall for four cycles
        in_valid = 1'b1;
        in_data = 32'h2AAAA;
        q3.push_back(18'h2AAAA);
        step();
        in_valid = 1'b0;
        en3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_ov", 32'(ov3), 32'd0);
        end
        en3 = 1'b1;
        step();
        chk("stall_e1_ov", 32'(ov3), 32'd0);
        step();
        chk("stall_e2_ov", 32'(ov3), 32'd1);
        chk("stall_e2_od", 32'(od3), 32'h2AAAA);
        step();
        chk("stall_done_ov", 32'(ov3), 32'd0);
        en3 = 1'b0;

        // Flush with en and in_valid high
        en4 = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h11 + 32'(i);
            step();
        end
`ifdef REG_DELAY_PIPE_OCC_EN
        chk("fl_occ_pre", 32'(occ4), 32'd3);
`endif
        chk("fl_ov_pre", 32'(ov4), 32'd0);
        flush = 1'b1;
        in_data = 32'h14;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_ov", 32'(ov4), 32'd0);
`ifdef REG_DELAY_PIPE_OCC_EN
        chk("fl_occ", 32'(occ4), 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_drain_ov", 32'(ov4), 32'd0);
        end
        en4 = 1'b0;

        // Continuous input: occupancy saturates at depth
        en3 = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'h100 + 32'(i);
            q3.push_back(18'h100 + 18'(i));
            step();
`ifdef REG_DELAY_PIPE_OCC_EN
            chk("occ_fill", 32'(occ3), (i < 3) ? 32'(i + 1) : 32'd3);
`endif
            chk("occ_fill_ov", 32'(ov3), (i >= 2) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
`ifdef REG_DELAY_PIPE_OCC_EN
            chk("occ_drain", 32'(occ3), 32'(2 - i));
`endif
        end
        chk("occ_drain_ov", 32'(ov3), 32'd0);

        // Asynchronous reset with two entries in flight
        in_valid = 1'b1;
        in_data = 32'h3F00;
        step();
        in_data = 32'h3F01;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", 32'(ov3), 32'd0);
        chk("arst_od", 32'(od3), 32'd0);
`ifdef REG_DELAY_PIPE_OCC_EN
        chk("arst_occ", 32'(occ3), 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h555;
        q3.push_back(18'h555);
        step();
        in_valid = 1'b0;
        chk("arst_e1_ov", 32'(ov3), 32'd0);
`ifdef REG_DELAY_PIPE_OCC_EN
        chk("arst_e1_occ", 32'(occ3), 32'd1);
`endif
        step();
        chk("arst_e2_ov", 32'(ov3), 32'd0);
        step();
        chk("arst_e3_ov", 32'(ov3), 32'd1);
        chk("arst_e3_od", 32'(od3), 32'h555);
        step();
        en3 = 1'b0;

        // Single stage, 32-bit
        en1 = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        q1.push_back(32'hDEADBEEF);
        chk("d1_pre_ov", 32'(ov1), 32'd0);
        step();
        in_valid = 1'b0;
        chk("d1_ov", 32'(ov1), 32'd1);
        chk("d1_od", od1, 32'hDEADBEEF);
        step();
        chk("d1_after_ov", 32'(ov1), 32'd0);
        en1 = 1'b0;

        step();
        step();
        chk("q3_empty", 32'(q3.size()), 32'd0);
        chk("q4_empty", 32'(q4.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_delay_pipe.md
REG_DELAY_PIPE -- requirements
Module: reg_delay_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 18: width of the data path in bits.
REQ-002 The block SHALL have parameter DEPTH, default 3: number of register stages, legal range 1..16.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: advance enable; 0 stalls every stage.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous clear of all valid flags.
REQ-007 The block SHALL have port in_valid, input, 1 bit: qualifies in_data.
REQ-008 The block SHALL have port in_data, input, DATA_WIDTH bits: data entering stage 1.
REQ-009 The block SHALL have port out_valid, output, 1 bit: valid flag of stage DEPTH.
REQ-010 The block SHALL have port out_data, output, DATA_WIDTH bits: data of stage DEPTH.
REQ-011 The block SHALL have port occupancy, output, $clog2(DEPTH+1) bits: count of valid stages (present only with REG_DELAY_PIPE_OCC_EN).

Function
REQ-012 Each stage SHALL hold a data register and a valid flag; stage 1 loads in_data/in_valid, and stage k loads stage k-1.
REQ-013 When en=1 and flush=0, all stages SHALL shift by one on the clock edge; latency in_data to out_data SHALL be exactly DEPTH enabled cycles.
REQ-014 When en=0 and flush=0, every data register and valid flag SHALL hold its value.
REQ-015 Data registers SHALL shift on en irrespective of valid, so DEPTH=3 with en tied high is bit-identical to the legacy three-register delay.
REQ-016 When flush=1, all valid flags SHALL be 0 after the edge regardless of en or in_valid, and data registers SHALL follow REQ-013/REQ-014 unchanged.
REQ-017 out_valid and out_data SHALL be driven directly from stage-DEPTH registers, with no combinational path from any input.
REQ-018 DEPTH=1 SHALL give a single-stage register with one-cycle latency.
REQ-019 DEPTH outside 1..16 SHALL cause an elaboration-time error.

Reset
REQ-020 On rst_n low, all valid flags, all data registers, out_valid, out_data and occupancy SHALL become 0 immediately, independent of clk.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight data, and the first enabled edge after release SHALL load stage 1 only.

Configuration
REQ-022 With macro REG_DELAY_PIPE_OCC_EN defined, occupancy SHALL be present and SHALL update each edge as follows: 0 on flush; otherwise, when en=1, occupancy + in_valid - (stage-DEPTH valid); otherwise unchanged.
REQ-023 With REG_DELAY_PIPE_OCC_EN defined, occupancy SHALL never exceed DEPTH, and simultaneous entry and exit SHALL leave it unchanged.
REQ-024 Without REG_DELAY_PIPE_OCC_EN, the occupancy port and its counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package reg_delay_pkg SHALL hold the constants REG_DELAY_MAX_DEPTH=16 and REG_DELAY_DEF_WIDTH=18, and a function returning the occupancy width for a given depth.
REQ-026 One stage SHALL be sub-module reg_delay_stage (clk, rst_n, en, flush, valid/data in and out), instantiated DEPTH times by a generate loop.

Verification
REQ-027 The bench SHALL cover this scenario: DEPTH=3, en=1, in_valid=1, in_data=0x00001,0x00002,0x00003 on cycles 0-2 -> out_data 0x00001,0x00002,0x00003 with out_valid=1 on cycles 3-5.
REQ-028 The bench SHALL cover this scenario: DEPTH=3, inject 0x2AAAA, deassert en for 4 cycles after 1 edge -> out_valid stays 0, and 0x2AAAA emerges after 2 further enabled edges.
REQ-029 The bench SHALL cover this scenario: DEPTH=4 with 3 valid entries, flush=1 together with en=1 and in_valid=1 -> every valid flag is 0 next cycle, out_valid=0, and occupancy=0.
REQ-030 The bench SHALL cover this scenario: DEPTH=3, OCC_EN defined, continuous in_valid=1 -> occupancy goes 1,2,3, then holds at 3 while input and output are both valid.
REQ-031 The bench SHALL cover this scenario: rst_n pulled low between clock edges with 2 entries in flight -> outputs go to 0 before the next edge, and no stale data emerges after release.
REQ-032 The bench SHALL cover this scenario: DEPTH=1, DATA_WIDTH=32, in_data=0xDEADBEEF -> out_data=0xDEADBEEF one edge later.
